// File: rtl/rob_queue_pkg.sv
// Shared types for the reorder buffer: instruction kinds held per entry
// and the per-entry control bits (data fields live in separate arrays).
package rob_queue_pkg;

    typedef enum logic [2:0] {
        K_ALU    = 3'd0,
        K_LOAD   = 3'd1,
        K_STORE  = 3'd2,
        K_BRANCH = 3'd3,
        K_JUMP   = 3'd4,
        K_DONE   = 3'd5
    } kind_e;

    // Control half of an entry; val/pc/target are XLEN-wide and kept
    // in parameterised arrays alongside this struct.
    typedef struct packed {
        logic       busy;
        logic       done;
        kind_e      kind;
        logic [4:0] rd;
        logic       pred;
        logic       taken;
    } ent_ctl_t;

    // Stores and decode-resolved results need no writeback.
    function automatic logic done_at_alloc(kind_e k);
        return (k == K_STORE) || (k == K_DONE);
    endfunction

endpackage

// File: rtl/rob_queue_if.sv
// Reorder buffer bus: allocation, two writeback ports, two operand
// queries, commit / store release / redirect. master = core side.
interface rob_queue_if #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32
);
    import rob_queue_pkg::*;
    localparam int TW = $clog2(DEPTH);

    logic            rdy;
    logic            alloc_valid;
    logic            alloc_ready;
    kind_e           alloc_kind;
    logic [4:0]      alloc_rd;
    logic [XLEN-1:0] alloc_val;
    logic [XLEN-1:0] alloc_pc;
    logic            alloc_pred;
    logic [TW-1:0]   alloc_tag;

    logic            wb_alu_valid;
    logic [TW-1:0]   wb_alu_tag;
    logic [XLEN-1:0] wb_alu_val;
    logic            wb_alu_taken;
    logic [XLEN-1:0] wb_alu_target;
    logic            wb_lsb_valid;
    logic [TW-1:0]   wb_lsb_tag;
    logic [XLEN-1:0] wb_lsb_val;

    logic [TW-1:0]   q1_tag;
    logic            q1_ready;
    logic [XLEN-1:0] q1_val;
    logic [TW-1:0]   q2_tag;
    logic            q2_ready;
    logic [XLEN-1:0] q2_val;

    logic            commit_valid;
    logic [4:0]      commit_rd;
    logic [XLEN-1:0] commit_val;
    logic [TW-1:0]   commit_tag;
    logic            store_commit;
    logic [TW-1:0]   store_tag;
    logic            flush;
    logic [XLEN-1:0] flush_pc;
    logic [TW:0]     count;
    logic            empty;

    modport master (
        output rdy, alloc_valid, alloc_kind, alloc_rd, alloc_val,
               alloc_pc, alloc_pred,
               wb_alu_valid, wb_alu_tag, wb_alu_val, wb_alu_taken,
               wb_alu_target, wb_lsb_valid, wb_lsb_tag, wb_lsb_val,
               q1_tag, q2_tag,
        input  alloc_ready, alloc_tag, q1_ready, q1_val, q2_ready,
               q2_val, commit_valid, commit_rd, commit_val, commit_tag,
               store_commit, store_tag, flush, flush_pc, count, empty
    );

    modport slave (
        input  rdy, alloc_valid, alloc_kind, alloc_rd, alloc_val,
               alloc_pc, alloc_pred,
               wb_alu_valid, wb_alu_tag, wb_alu_val, wb_alu_taken,
               wb_alu_target, wb_lsb_valid, wb_lsb_tag, wb_lsb_val,
               q1_tag, q2_tag,
        output alloc_ready, alloc_tag, q1_ready, q1_val, q2_ready,
               q2_val, commit_valid, commit_rd, commit_val, commit_tag,
               store_commit, store_tag, flush, flush_pc, count, empty
    );

endinterface

// File: rtl/rob_queue_query_port.sv
// Operand lookup: returns the entry value if done, forwarding a
// same-cycle writeback (LSB over ALU); otherwise the tag itself.
module rob_query_port #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32,
    parameter int TW    = $clog2(DEPTH)
) (
    input  logic [TW-1:0]               q_tag,
    input  logic [DEPTH-1:0]            done_vec,
    input  logic [DEPTH-1:0][XLEN-1:0]  val_vec,
    input  logic                        wb_alu_valid,
    input  logic [TW-1:0]               wb_alu_tag,
    input  logic [XLEN-1:0]             wb_alu_val,
    input  logic                        wb_lsb_valid,
    input  logic [TW-1:0]               wb_lsb_tag,
    input  logic [XLEN-1:0]             wb_lsb_val,
    output logic                        q_ready,
    output logic [XLEN-1:0]             q_val
);

    always_comb begin
        q_ready = 1'b0;
        q_val   = XLEN'(q_tag);
        if (wb_lsb_valid && wb_lsb_tag == q_tag) begin
            q_ready = 1'b1;
            q_val   = wb_lsb_val;
        end else if (wb_alu_valid && wb_alu_tag == q_tag) begin
            q_ready = 1'b1;
            q_val   = wb_alu_val;
        end else if (done_vec[q_tag]) begin
            q_ready = 1'b1;
            q_val   = val_vec[q_tag];
        end
    end

endmodule

// File: rtl/rob_queue.sv
// Reorder buffer: circular queue with occupancy count, two writeback
// ports, two bypassing operand queries, in-order commit with flush.
// Ports: clk, rst (sync, active high), bus (rob_queue_if.slave).
module rob_queue
    import rob_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32
) (
    input  logic          clk,
    input  logic          rst,
    rob_queue_if.slave    bus
);

    localparam int TW = $clog2(DEPTH);
    localparam logic [TW:0] FULL = (TW+1)'(DEPTH);

    ent_ctl_t        ctl   [DEPTH];
    logic [XLEN-1:0] val_q [DEPTH];
    logic [XLEN-1:0] pc_q  [DEPTH];
    logic [XLEN-1:0] tgt_q [DEPTH];
    logic [TW-1:0]   head, tail;
    logic [TW:0]     cnt;

    logic            cv_q, sc_q, fl_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] cval_q, fpc_q;
    logic [TW-1:0]   ctag_q, stag_q;

    ent_ctl_t        hd;
    logic            commit, n_cv, n_sc, n_fl;
    logic [XLEN-1:0] n_fpc;
    logic            alloc_fire, alu_fire, lsb_fire;

    logic [DEPTH-1:0]           done_vec;
    logic [DEPTH-1:0][XLEN-1:0] val_vec;

    assign bus.alloc_ready  = cnt < FULL;
    assign bus.alloc_tag    = tail;
    assign bus.count        = cnt;
    assign bus.empty        = (cnt == '0);
    assign bus.commit_valid = cv_q;
    assign bus.commit_rd    = rd_q;
    assign bus.commit_val   = cval_q;
    assign bus.commit_tag   = ctag_q;
    assign bus.store_commit = sc_q;
    assign bus.store_tag    = stag_q;
    assign bus.flush        = fl_q;
    assign bus.flush_pc     = fpc_q;

    assign hd     = ctl[head];
    assign commit = bus.rdy && hd.busy && hd.done;

    always_comb begin
        n_cv  = 1'b0;
        n_sc  = 1'b0;
        n_fl  = 1'b0;
        n_fpc = '0;
        if (commit) begin
            unique case (hd.kind)
                K_STORE: n_sc = 1'b1;
                K_BRANCH: begin
                    n_fl  = (hd.taken != hd.pred);
                    n_fpc = hd.taken ? tgt_q[head]
                                     : pc_q[head] + XLEN'(4);
                end
                K_JUMP: begin
                    n_cv  = (hd.rd != 5'd0);
                    n_fl  = 1'b1;
                    n_fpc = tgt_q[head];
                end
                default: n_cv = (hd.rd != 5'd0);
            endcase
        end
    end

    // A redirect discards everything else happening this cycle.
    // Same-tag dual writeback lets LSB win outright.
    assign alloc_fire = bus.rdy && !n_fl && bus.alloc_valid
                        && bus.alloc_ready;
    assign lsb_fire   = bus.rdy && !n_fl && bus.wb_lsb_valid
                        && ctl[bus.wb_lsb_tag].busy;
    assign alu_fire   = bus.rdy && !n_fl && bus.wb_alu_valid
                        && ctl[bus.wb_alu_tag].busy
                        && !(bus.wb_lsb_valid
                             && bus.wb_lsb_tag == bus.wb_alu_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ctl[i] <= '0;
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            cv_q   <= 1'b0;
            sc_q   <= 1'b0;
            fl_q   <= 1'b0;
            rd_q   <= '0;
            cval_q <= '0;
            ctag_q <= '0;
            stag_q <= '0;
            fpc_q  <= '0;
        end else if (!bus.rdy) begin
            cv_q <= 1'b0;
            sc_q <= 1'b0;
            fl_q <= 1'b0;
        end else begin
            cv_q <= n_cv;
            sc_q <= n_sc;
            fl_q <= n_fl;
            if (n_cv) begin
                rd_q   <= hd.rd;
                cval_q <= val_q[head];
                ctag_q <= head;
            end
            if (n_sc) stag_q <= head;
            if (n_fl) fpc_q <= n_fpc;
            if (n_fl) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ctl[i].busy <= 1'b0;
                    ctl[i].done <= 1'b0;
                end
                head <= '0;
                tail <= '0;
                cnt  <= '0;
            end else begin
                if (alu_fire) begin
                    ctl[bus.wb_alu_tag].done  <= 1'b1;
                    ctl[bus.wb_alu_tag].taken <= bus.wb_alu_taken;
                end
                if (lsb_fire) ctl[bus.wb_lsb_tag].done <= 1'b1;
                if (commit) begin
                    ctl[head].busy <= 1'b0;
                    ctl[head].done <= 1'b0;
                    head <= head + 1'b1;
                end
                // Tail is never busy when allocation is allowed, so this
                // cannot collide with the writeback/commit updates above.
                if (alloc_fire) begin
                    ctl[tail] <= '{busy:  1'b1,
                                   done:  done_at_alloc(bus.alloc_kind),
                                   kind:  bus.alloc_kind,
                                   rd:    bus.alloc_rd,
                                   pred:  bus.alloc_pred,
                                   taken: 1'b0};
                    tail <= tail + 1'b1;
                end
                cnt <= cnt + (TW+1)'(alloc_fire) - (TW+1)'(commit);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            val_q[tail] <= bus.alloc_val;
            pc_q[tail]  <= bus.alloc_pc;
        end
        if (alu_fire) begin
            val_q[bus.wb_alu_tag] <= bus.wb_alu_val;
            tgt_q[bus.wb_alu_tag] <= bus.wb_alu_target;
        end
        if (lsb_fire) val_q[bus.wb_lsb_tag] <= bus.wb_lsb_val;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            done_vec[i] = ctl[i].done;
            val_vec[i]  = val_q[i];
        end
    end

    rob_query_port #(.DEPTH(DEPTH), .XLEN(XLEN), .TW(TW)) u_q1 (
        .q_tag        (bus.q1_tag),
        .done_vec     (done_vec),
        .val_vec      (val_vec),
        .wb_alu_valid (bus.wb_alu_valid),
        .wb_alu_tag   (bus.wb_alu_tag),
        .wb_alu_val   (bus.wb_alu_val),
        .wb_lsb_valid (bus.wb_lsb_valid),
        .wb_lsb_tag   (bus.wb_lsb_tag),
        .wb_lsb_val   (bus.wb_lsb_val),
        .q_ready      (bus.q1_ready),
        .q_val        (bus.q1_val)
    );

    rob_query_port #(.DEPTH(DEPTH), .XLEN(XLEN), .TW(TW)) u_q2 (
        .q_tag        (bus.q2_tag),
        .done_vec     (done_vec),
        .val_vec      (val_vec),
        .wb_alu_valid (bus.wb_alu_valid),
        .wb_alu_tag   (bus.wb_alu_tag),
        .wb_alu_val   (bus.wb_alu_val),
        .wb_lsb_valid (bus.wb_lsb_valid),
        .wb_lsb_tag   (bus.wb_lsb_tag),
        .wb_lsb_val   (bus.wb_lsb_val),
        .q_ready      (bus.q2_ready),
        .q_val        (bus.q2_val)
    );

endmodule

// File: tb/tb_rob_queue.sv
// Reorder buffer bench: in-order queue reference model, scoreboard of
// expected commit/store/flush pulses, directed cases then random traffic.
module tb_rob_queue;
    import rob_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rob_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();
    rob_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        kind_e       kind;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] pc;
        logic [31:0] target;
        bit          pred;
        bit          taken;
        bit          done;
        int          tag;
    } m_ent_t;

    typedef struct {
        bit          cv;
        logic [4:0]  rd;
        logic [31:0] val;
        int          tag;
        bit          sc;
        bit          fl;
        logic [31:0] fpc;
    } exp_t;

    m_ent_t mq[$];
    exp_t   sb[$];
    int     next_tag = 0;
    int     tests = 0;
    int     fails = 0;
    bit     mon_en = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every pulse the DUT presents must match the next
    // expected retirement event.
    always @(negedge clk) begin
        exp_t x;
        if (mon_en && (bus.commit_valid || bus.store_commit || bus.flush))
        begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {bus.commit_valid,
                    bus.store_commit, bus.flush}, 0);
            end else begin
                x = sb.pop_front();
                chk("commit_valid", bus.commit_valid, x.cv);
                chk("store_commit", bus.store_commit, x.sc);
                chk("flush", bus.flush, x.fl);
                if (x.cv) begin
                    chk("commit_rd", bus.commit_rd, x.rd);
                    chk("commit_val", bus.commit_val, x.val);
                    chk("commit_tag", bus.commit_tag, x.tag);
                end
                if (x.sc) chk("store_tag", bus.store_tag, x.tag);
                if (x.fl) chk("flush_pc", bus.flush_pc, x.fpc);
            end
        end
    end

    function automatic void qexp(input int tag, output bit r,
                                 output logic [31:0] v);
        r = 0;
        v = 32'(tag);
        foreach (mq[i])
            if (mq[i].tag == tag && mq[i].done) begin
                r = 1;
                v = mq[i].val;
            end
        if (bus.wb_alu_valid && int'(bus.wb_alu_tag) == tag) begin
            r = 1;
            v = bus.wb_alu_val;
        end
        if (bus.wb_lsb_valid && int'(bus.wb_lsb_tag) == tag) begin
            r = 1;
            v = bus.wb_lsb_val;
        end
    endfunction

    task automatic check_comb();
        bit r;
        logic [31:0] v;
        chk("count", bus.count, mq.size());
        chk("alloc_ready", bus.alloc_ready, mq.size() < DEPTH);
        chk("empty", bus.empty, mq.size() == 0);
        chk("alloc_tag", bus.alloc_tag, next_tag);
        qexp(int'(bus.q1_tag), r, v);
        chk("q1_ready", bus.q1_ready, r);
        chk("q1_val", bus.q1_val, v);
        qexp(int'(bus.q2_tag), r, v);
        chk("q2_ready", bus.q2_ready, r);
        chk("q2_val", bus.q2_val, v);
    endtask

    // Reference step: retire oldest finished entry, redirect if needed,
    // else apply writebacks then append the new instruction.
    task automatic model_step();
        m_ent_t e;
        exp_t   x;
        int     sz;
        bit     fl;
        bit     same;
        fl = 0;
        if (!bus.rdy) return;
        sz = mq.size();
        if (sz > 0 && mq[0].done) begin
            e = mq.pop_front();
            x = '{cv: 0, rd: e.rd, val: e.val, tag: e.tag, sc: 0,
                  fl: 0, fpc: 0};
            case (e.kind)
                K_STORE: x.sc = 1;
                K_BRANCH:
                    if (e.taken != e.pred) begin
                        x.fl  = 1;
                        x.fpc = e.taken ? e.target : e.pc + 32'd4;
                    end
                K_JUMP: begin
                    x.cv  = (e.rd != 0);
                    x.fl  = 1;
                    x.fpc = e.target;
                end
                default: x.cv = (e.rd != 0);
            endcase
            if (x.cv || x.sc || x.fl) sb.push_back(x);
            fl = x.fl;
        end
        if (fl) begin
            mq.delete();
            next_tag = 0;
            return;
        end
        same = bus.wb_alu_valid && bus.wb_lsb_valid
               && bus.wb_alu_tag == bus.wb_lsb_tag;
        foreach (mq[i]) begin
            if (bus.wb_alu_valid && !same
                && mq[i].tag == int'(bus.wb_alu_tag)) begin
                mq[i].done   = 1;
                mq[i].val    = bus.wb_alu_val;
                mq[i].taken  = bus.wb_alu_taken;
                mq[i].target = bus.wb_alu_target;
            end
            if (bus.wb_lsb_valid && mq[i].tag == int'(bus.wb_lsb_tag))
            begin
                mq[i].done = 1;
                mq[i].val  = bus.wb_lsb_val;
            end
        end
        if (bus.alloc_valid && sz < DEPTH) begin
            e = '{kind: bus.alloc_kind, rd: bus.alloc_rd,
                  val: bus.alloc_val, pc: bus.alloc_pc, target: 0,
                  pred: bus.alloc_pred, taken: 0,
                  done: (bus.alloc_kind == K_STORE
                         || bus.alloc_kind == K_DONE),
                  tag: next_tag};
            mq.push_back(e);
            next_tag = (next_tag + 1) % DEPTH;
        end
    endtask

    task automatic step();
        #1;
        check_comb();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.rdy          = 1;
        bus.alloc_valid  = 0;
        bus.alloc_kind   = K_ALU;
        bus.alloc_rd     = 0;
        bus.alloc_val    = 0;
        bus.alloc_pc     = 0;
        bus.alloc_pred   = 0;
        bus.wb_alu_valid = 0;
        bus.wb_alu_tag   = 0;
        bus.wb_alu_val   = 0;
        bus.wb_alu_taken = 0;
        bus.wb_alu_target = 0;
        bus.wb_lsb_valid = 0;
        bus.wb_lsb_tag   = 0;
        bus.wb_lsb_val   = 0;
        bus.q1_tag       = 0;
        bus.q2_tag       = 0;
    endtask

    task automatic alloc(kind_e k, int rd, logic [31:0] v,
                         logic [31:0] pc, bit pred);
        idle();
        bus.alloc_valid = 1;
        bus.alloc_kind  = k;
        bus.alloc_rd    = 5'(rd);
        bus.alloc_val   = v;
        bus.alloc_pc    = pc;
        bus.alloc_pred  = pred;
        step();
    endtask

    task automatic wb_alu(int tag, logic [31:0] v, bit tk,
                          logic [31:0] tgt);
        idle();
        bus.wb_alu_valid  = 1;
        bus.wb_alu_tag    = 2'(tag);
        bus.wb_alu_val    = v;
        bus.wb_alu_taken  = tk;
        bus.wb_alu_target = tgt;
        step();
    endtask

    task automatic idle_steps(int n);
        for (int i = 0; i < n; i++) begin
            idle();
            step();
        end
    endtask

    task automatic rand_inputs(bit allow_alloc);
        int pa[$];
        int pl[$];
        idle();
        bus.rdy         = ($urandom % 10) != 0;
        bus.alloc_valid = allow_alloc && ($urandom % 3 != 0);
        bus.alloc_kind  = kind_e'(3'($urandom % 6));
        bus.alloc_rd    = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
        bus.alloc_val   = $urandom;
        bus.alloc_pc    = $urandom & 32'hFFFF_FFFC;
        bus.alloc_pred  = $urandom % 2;
        foreach (mq[i])
            if (!mq[i].done) begin
                if (mq[i].kind == K_LOAD) pl.push_back(mq[i].tag);
                else pa.push_back(mq[i].tag);
            end
        bus.wb_alu_val    = $urandom;
        bus.wb_alu_target = $urandom & 32'hFFFF_FFFC;
        bus.wb_alu_taken  = $urandom % 2;
        if (pa.size() > 0 && $urandom % 10 < 7) begin
            bus.wb_alu_valid = 1;
            bus.wb_alu_tag   = 2'(pa[$urandom % pa.size()]);
            foreach (mq[i])
                if (mq[i].tag == int'(bus.wb_alu_tag) && $urandom % 4 != 0)
                    bus.wb_alu_taken = mq[i].pred;
        end else if ($urandom % 10 == 0) begin
            bus.wb_alu_valid = 1;
            bus.wb_alu_tag   = 2'($urandom);
        end
        bus.wb_lsb_val = $urandom;
        if (pl.size() > 0 && $urandom % 10 < 7) begin
            bus.wb_lsb_valid = 1;
            bus.wb_lsb_tag   = 2'(pl[$urandom % pl.size()]);
            if (bus.wb_alu_valid && bus.wb_alu_tag == bus.wb_lsb_tag)
                bus.wb_lsb_valid = 0;
        end
        bus.q1_tag = ($urandom % 3 == 0) ? bus.wb_alu_tag : 2'($urandom);
        bus.q2_tag = ($urandom % 3 == 0) ? bus.wb_lsb_tag : 2'($urandom);
    endtask

    initial begin
        bit seen;
        idle();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("rst_alloc_ready", bus.alloc_ready, 1);
        chk("rst_empty", bus.empty, 1);
        chk("rst_count", bus.count, 0);
        chk("rst_alloc_tag", bus.alloc_tag, 0);
        chk("rst_pulses", {bus.commit_valid, bus.store_commit, bus.flush}, 0);
        chk("rst_flush_pc", bus.flush_pc, 0);
        mon_en = 1;

        // Fill to capacity, then complete out of order.
        for (int i = 0; i < DEPTH; i++) alloc(K_ALU, i + 1, 0, 32'h40, 0);
        idle();
        chk("full_ready", bus.alloc_ready, 0);
        chk("full_count", bus.count, 4);
        wb_alu(1, 32'h11, 0, 0);
        wb_alu(0, 32'h10, 0, 0);
        wb_alu(2, 32'h12, 0, 0);
        wb_alu(3, 32'h13, 0, 0);
        idle_steps(4);
        chk("drained_empty", bus.empty, 1);

        // Wrapped tags and same-cycle operand bypass.
        alloc(K_ALU, 5, 0, 32'h50, 0);
        alloc(K_ALU, 6, 0, 32'h54, 0);
        idle();
        bus.q1_tag       = 2'd1;
        bus.wb_alu_valid = 1;
        bus.wb_alu_tag   = 2'd1;
        bus.wb_alu_val   = 32'hABCD;
        #1;
        chk("bypass_ready", bus.q1_ready, 1);
        chk("bypass_val", bus.q1_val, 32'hABCD);
        step();
        wb_alu(0, 32'h77, 0, 0);
        idle_steps(3);

        // Mispredicted not-taken branch discards younger work.
        alloc(K_BRANCH, 0, 0, 32'h100, 1);
        alloc(K_ALU, 7, 0, 32'h104, 0);
        alloc(K_DONE, 8, 32'h55, 32'h108, 0);
        wb_alu(2, 0, 0, 32'h300);
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            idle();
            step();
            if (bus.flush) begin
                seen = 1;
                chk("br_flush_pc", bus.flush_pc, 32'h104);
                chk("br_count", bus.count, 0);
                chk("br_empty", bus.empty, 1);
            end
        end
        chk("br_flush_seen", seen, 1);
        idle_steps(2);

        // JALR: link write and redirect in one cycle.
        alloc(K_JUMP, 1, 0, 32'h200, 0);
        wb_alu(0, 32'h208, 1, 32'h400);
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            idle();
            step();
            if (bus.commit_valid) begin
                seen = 1;
                chk("jmp_rd", bus.commit_rd, 1);
                chk("jmp_val", bus.commit_val, 32'h208);
                chk("jmp_flush", bus.flush, 1);
                chk("jmp_flush_pc", bus.flush_pc, 32'h400);
            end
        end
        chk("jmp_seen", seen, 1);

        // Store release, then an rd=0 ALU that must not write.
        alloc(K_STORE, 3, 0, 32'h500, 0);
        idle();
        #1;
        seen = 0;
        alloc(K_ALU, 0, 0, 32'h504, 0);
        if (bus.store_commit) begin
            seen = 1;
            chk("st_cv", bus.commit_valid, 0);
            chk("st_tag", bus.store_tag, 0);
        end
        chk("st_seen", seen, 1);
        wb_alu(1, 32'h99, 0, 0);
        idle_steps(3);

        for (int i = 0; i < 3000; i++) begin
            rand_inputs(1);
            step();
        end
        for (int i = 0; i < 120; i++) begin
            rand_inputs(0);
            step();
        end
        idle_steps(3);
        chk("end_count", bus.count, mq.size());
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rob_queue.md
# rob_queue

Parametrised reorder buffer that succeeds the fixed 16-entry ROB: configurable depth and data width, occupancy-counted full/empty, two writeback ports (ALU, LSB), two operand-query ports with same-cycle writeback bypass, and in-order single commit with branch/jump misprediction flush. It sits between decode/issue (allocation, operand lookup) and the register file, LSB and IF (commit, store release, redirect).

## Interface
- DEPTH, 16, entry count; power of two, ≥2
- XLEN, 32, data/PC width
- TW, $clog2(DEPTH), tag width (derived, not overridable)
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- alloc_valid  in  1  decode offers an instruction
- alloc_ready  out  1  count < DEPTH
- alloc_kind  in  3  ALU/LOAD/STORE/BRANCH/JUMP/DONE (DONE = result known at decode, e.g. LUI/AUIPC/JAL)
- alloc_rd  in  5  destination register (0 = none)
- alloc_val  in  XLEN  result for DONE kind
- alloc_pc  in  XLEN  instruction PC
- alloc_pred  in  1  predicted taken (BRANCH)
- alloc_tag  out  TW  tag of the entry being allocated (= tail), combinational
- wb_alu_valid / wb_alu_tag / wb_alu_val / wb_alu_taken / wb_alu_target  in  1/TW/XLEN/1/XLEN  ALU result
- wb_lsb_valid / wb_lsb_tag / wb_lsb_val  in  1/TW/XLEN  load result
- q1_tag, q2_tag  in  TW  operand query; q1_ready, q2_ready  out  1; q1_val, q2_val  out  XLEN
- commit_valid  out  1  register-writing commit pulse; commit_rd  out  5; commit_val  out  XLEN; commit_tag  out  TW
- store_commit  out  1  head store released to LSB; store_tag  out  TW
- flush  out  1  redirect pulse; flush_pc  out  XLEN
- count  out  TW+1  occupancy; empty  out  1

## Operation
- Circular buffer, head/tail pointers TW bits, wrap naturally; separate count register (no pointer-equality ambiguity).
- Allocate when alloc_valid && alloc_ready && rdy: write entry at tail, busy=1, done=(kind==STORE||kind==DONE), tail+1, count+1.
- Writeback: sets done, val; ALU also stores taken/target. Writeback to non-busy tag ignored. Both ports same tag same cycle: LSB wins (illegal by construction, must not corrupt other entries).
- Query: ready=1 with val if entry done, or if matching wb port valid this cycle (LSB before ALU); else ready=0, val={tag zero-extended}.
- Commit: head busy && done, one per cycle. STORE → store_commit. ALU/LOAD/DONE → commit_valid if rd≠0. BRANCH → no reg write; if taken≠pred → flush, flush_pc = taken ? target : pc+4. JUMP (JALR) → commit_valid with link val, always flush to target.
- Flush: all busy cleared, head=tail=0, count=0 next cycle; same-cycle allocation and writebacks discarded.
- Same-cycle alloc+commit: count unchanged. alloc_ready uses registered count (no commit bypass).

## Timing
- Reset: all outputs 0 except alloc_ready=1, empty=1; head=tail=count=0, all busy/done=0. Reset mid-flush or mid-commit wins.
- Commit/store/flush outputs registered, single-cycle pulses; deasserted on any cycle with no commit, and while rdy=0.
- DONE/STORE allocated at edge t → commit outputs after edge t+1 if at head.
- Writeback at edge t → commit outputs after edge t+1 at earliest.
- Flush pulse at edge t → alloc_ready=1, empty=1 after edge t; new allocation accepted from cycle after t.

## Structure
- rob_pkg: kind enum (ALU, LOAD, STORE, BRANCH, JUMP, DONE), entry struct (busy, done, kind, rd, val, pc, pred, taken, target).
- Sub-module rob_query_port (tag lookup + wb bypass), instantiated twice.

## Test plan
- Reset, DEPTH=4: alloc 4 DONE entries with no commit stall via rdy → alloc_ready=0 after 4th, count=4; release → commits rd/val in order, tags 0,1,2,3, empty=1.
- Wrap: 6 ALU allocs with out-of-order wb (tag1 val 0x11 before tag0 val 0x10) → commits 0x10 then 0x11; tags wrap 3→0.
- Bypass: q1_tag=2 while wb_alu tag 2 val 0xABCD → q1_ready=1, q1_val=0xABCD same cycle.
- BRANCH pc 0x100 pred=1, wb taken=0 → flush=1, flush_pc=0x104; younger entries discarded, count=0.
- JUMP rd=1, val 0x208, target 0x400 → commit_valid rd=1 val 0x208 and flush_pc=0x400 same cycle.
- STORE at head → store_commit=1, commit_valid=0; rd=0 ALU → no commit_valid.
